// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm sequencer.
//   NOTE_REST / NOTE_END : special ROM note codes
//   SCORE_MAX            : score saturation ceiling
//   ROM_DEFAULT          : stored songs, entry {song,idx} at bits [4*entry +: 4]
//   state_t              : sequencer FSM encoding
//   note_onehot()        : note code 1..8 -> LED target, 0 for rest/END
package rhythm_pkg;

   localparam logic [3:0] NOTE_REST = 4'h0;
   localparam logic [3:0] NOTE_END  = 4'hF;
   localparam logic [6:0] SCORE_MAX = 7'd99;
   localparam int         ROM_DEPTH = 64;

   // song1: up-and-down scale; song0: opening phrase of "Twinkle Twinkle"
   localparam logic [4*ROM_DEPTH-1:0] ROM_DEFAULT =
      256'hFFFFFFFFFFFFFFFF_1234567887654321_FFFFFFFFFFFFFFFF_F122334405665511;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // codes outside 1..8 shift the bit out entirely, giving 0
   function automatic logic [7:0] note_onehot(input logic [3:0] code);
      return 8'h01 << (code - 4'd1);
   endfunction

endpackage

// File: rtl/rhythm_sequencer_song_rom.sv
// Two-song note ROM, 2 x 32 entries of 4 bits, one-cycle registered read.
//   CLK, RESETN : clock, async active-high reset
//   addr        : {song_sel, idx}
//   rd_data     : note code, valid the cycle after addr is presented
module song_rom
   import rhythm_pkg::*;
#(
   parameter logic [4*ROM_DEPTH-1:0] INIT = ROM_DEFAULT
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [5:0] addr,
   output logic [3:0] rd_data
);

   logic [3:0] data_d;
   logic [3:0] data_q;

   always_comb begin
      data_d = INIT[{addr, 2'b00} +: 4];
   end

   always_ff @(posedge CLK or posedge RESETN) begin
      if (RESETN) data_q <= 4'h0;
      else        data_q <= data_d;
   end

   assign rd_data = data_q;

endmodule

// File: rtl/rhythm_sequencer.sv
// Song playback and key-press judging controller.
//   CLK, RESETN     : clock, async active-high reset
//   start, abort    : menu controls (start is edge-detected, abort wins)
//   song_sel        : song choice, latched when a start is accepted
//   key[7:0]        : raw asynchronous push buttons
//   note, led       : tone code to piezo, one-hot target to LED bank
//   score           : saturating hit count (0..99)
//   hit, miss       : one-cycle judgement pulses
//   busy, done      : status (LOAD/PLAY, DONE)
//
// state | meaning
// IDLE  | quiet, waiting for start edge
// LOAD  | one cycle, ROM read for current idx settles
// PLAY  | note slot running, slot timer counting down
// DONE  | song finished, score held
module rhythm_sequencer
   import rhythm_pkg::*;
#(
   parameter int                     NOTE_CYC  = 12_500_000,
   parameter int                     WIN_CYC   = 6_250_000,
   parameter int                     MAX_NOTES = 32,
   parameter logic [4*ROM_DEPTH-1:0] ROM_INIT  = ROM_DEFAULT
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       start,
   input  logic       abort,
   input  logic       song_sel,
   input  logic [7:0] key,
   output logic [3:0] note,
   output logic [7:0] led,
   output logic [6:0] score,
   output logic       hit,
   output logic       miss,
   output logic       busy,
   output logic       done
);

   localparam int             CW       = $clog2(NOTE_CYC);
   localparam logic [CW-1:0]  REM_TOP  = CW'(NOTE_CYC - 1);
   // remaining count seen when the up-count equals WIN_CYC-1 (last in-window cycle)
   localparam logic [CW-1:0]  REM_WEND = CW'(NOTE_CYC - WIN_CYC);
   localparam logic [4:0]     IDX_LAST = 5'(MAX_NOTES - 1);

   state_t        state_q, state_d;
   logic [4:0]    idx_q, idx_d;
   logic          sel_q, sel_d;
   logic [CW-1:0] rem_q, rem_d;
   logic          lock_q, lock_d;
   logic [3:0]    note_q, note_d;
   logic [7:0]    led_q, led_d;
   logic [6:0]    score_q, score_d;
   logic          hit_q, hit_d;
   logic          miss_q, miss_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          start_q;
   logic [7:0]    key_s1_q, key_s2_q, key_s3_q, kedge_q;
   logic [5:0]    rom_addr;
   logic [3:0]    rom_data;
   logic          start_rise;
   logic          in_win;
   logic          win_end;

   song_rom #(.INIT(ROM_INIT)) u_rom (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .addr    (rom_addr),
      .rd_data (rom_data)
   );

   always_comb begin
      start_rise = start & ~start_q;
      in_win     = (rem_q >= REM_WEND);
      win_end    = (rem_q == REM_WEND);

      state_d = state_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      rem_d   = rem_q;
      lock_d  = lock_q;
      note_d  = note_q;
      score_d = score_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
         note_d  = NOTE_REST;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               note_d = NOTE_REST;
               if (start_rise) begin
                  state_d = ST_LOAD;
                  idx_d   = 5'd0;
                  sel_d   = song_sel;
                  score_d = 7'd0;
               end
            end
            ST_LOAD: begin
               state_d = ST_PLAY;
               rem_d   = REM_TOP;
               lock_d  = 1'b0;
               note_d  = rom_data;
            end
            ST_PLAY: begin
               if (!lock_q && note_q != NOTE_REST) begin
                  if (in_win && kedge_q != 8'h00) begin
                     lock_d = 1'b1;
                     if (kedge_q == led_q) begin
                        hit_d = 1'b1;
                        if (score_q < SCORE_MAX) score_d = score_q + 7'd1;
                     end else begin
                        miss_d = 1'b1;
                     end
                  end else if (win_end) begin
                     // registered, so the timeout miss lands on count WIN_CYC
                     lock_d = 1'b1;
                     miss_d = 1'b1;
                  end
               end
               if (rem_q == '0) begin
                  note_d = NOTE_REST;
                  // during PLAY the ROM is already looking at idx+1
                  if (idx_q == IDX_LAST || rom_data == NOTE_END) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_LOAD;
                     idx_d   = idx_q + 5'd1;
                  end
               end else begin
                  rem_d = rem_q - CW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      led_d  = note_onehot(note_d);
      busy_d = (state_d == ST_LOAD) || (state_d == ST_PLAY);
      done_d = (state_d == ST_DONE);

      // addressed from next-state values: LOAD reads idx, PLAY pre-reads idx+1
      rom_addr = {sel_d, (state_d == ST_PLAY) ? idx_d + 5'd1 : idx_d};
   end

   always_ff @(posedge CLK or posedge RESETN) begin
      if (RESETN) begin
         state_q  <= ST_IDLE;
         idx_q    <= 5'd0;
         sel_q    <= 1'b0;
         rem_q    <= '0;
         lock_q   <= 1'b0;
         note_q   <= NOTE_REST;
         led_q    <= 8'h00;
         score_q  <= 7'd0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         start_q  <= 1'b0;
         key_s1_q <= 8'h00;
         key_s2_q <= 8'h00;
         key_s3_q <= 8'h00;
         kedge_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sel_q    <= sel_d;
         rem_q    <= rem_d;
         lock_q   <= lock_d;
         note_q   <= note_d;
         led_q    <= led_d;
         score_q  <= score_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         start_q  <= start;
         key_s1_q <= key;
         key_s2_q <= key_s1_q;
         key_s3_q <= key_s2_q;
         kedge_q  <= key_s2_q & ~key_s3_q;
      end
   end

   assign note  = note_q;
   assign led   = led_q;
   assign score = score_q;
   assign hit   = hit_q;
   assign miss  = miss_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_rhythm_sequencer.sv
module tb_rhythm_sequencer;

   localparam logic [255:0] TEST_ROM =
      256'h22222222_22222222_22222222_22222222_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF8031;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic       start, abort, song_sel;
   logic [7:0] key;
   logic [3:0] note;
   logic [7:0] led;
   logic [6:0] score;
   logic       hit, miss, busy, done;

   int checks = 0;
   int errors = 0;

   rhythm_sequencer #(
      .NOTE_CYC  (16),
      .WIN_CYC   (8),
      .MAX_NOTES (32),
      .ROM_INIT  (TEST_ROM)
   ) dut (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .start    (start),
      .abort    (abort),
      .song_sel (song_sel),
      .key      (key),
      .note     (note),
      .led      (led),
      .score    (score),
      .hit      (hit),
      .miss     (miss),
      .busy     (busy),
      .done     (done)
   );

   always #5 CLK = ~CLK;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic seen;

   initial begin
      RESETN   = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      song_sel = 1'b0;
      key      = 8'h00;
      step(2);
      chk("rst_note", note, 4'h0);
      chk("rst_led", led, 8'h00);
      chk("rst_score", score, 7'd0);
      chk("rst_pulses", {hit, miss}, 2'b00);
      chk("rst_status", {busy, done}, 2'b00);
      RESETN = 1'b0;
      step(2);

      // song0: 1,3,0,8,END
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("load_busy", busy, 1'b1);
      chk("load_note", note, 4'h0);
      step(1);                                // P, counter 0
      chk("s0_note", note, 4'd1);
      chk("s0_led", led, 8'h01);
      step(2);
      key = 8'h01;                            // P+2
      step(1);
      key = 8'h00;
      step(3);                                // P+6
      chk("s0_hit", hit, 1'b1);
      chk("s0_nomiss", miss, 1'b0);
      chk("s0_score", score, 7'd1);
      step(1);
      chk("s0_hit_pulse", hit, 1'b0);
      step(9);                                // P+16, LOAD
      chk("artic_note", note, 4'h0);
      step(1);                                // S1 = P+17
      chk("s1_note", note, 4'd3);
      chk("s1_led", led, 8'h04);
      key = 8'h02;
      step(1);
      key = 8'h00;
      step(3);                                // S1+4
      chk("s1_miss", miss, 1'b1);
      chk("s1_nohit", hit, 1'b0);
      key = 8'h04;
      step(1);
      key = 8'h00;
      step(3);                                // S1+8: late correct press and timeout both locked out
      chk("s1_locked", {hit, miss}, 2'b00);
      chk("s1_score", score, 7'd1);
      step(9);                                // S2 = P+34, rest
      chk("s2_note", note, 4'h0);
      chk("s2_led", led, 8'h00);
      key = 8'hFF;
      step(1);
      key = 8'h00;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(1);
         seen = seen | hit | miss;
      end
      chk("s2_rest_quiet", seen, 1'b0);       // now at S2+16, LOAD
      step(1);                                // S3 = P+51
      chk("s3_led", led, 8'h80);
      step(7);                                // counter 7
      chk("s3_pre_timeout", miss, 1'b0);
      key = 8'h80;                            // kedge lands at counter 10
      step(1);                                // counter 8
      key = 8'h00;
      chk("s3_timeout_miss", miss, 1'b1);
      chk("s3_timeout_nohit", hit, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(1);
         seen = seen | hit | miss;
      end
      chk("s3_late_ignored", seen, 1'b0);     // now P+66
      chk("pre_done", done, 1'b0);
      step(1);                                // P+67
      chk("done_at_67", done, 1'b1);
      chk("done_note", note, 4'h0);
      chk("done_led", led, 8'h00);
      chk("done_busy", busy, 1'b0);
      chk("done_score_held", score, 7'd1);

      // song1: 32 x code 2, score preloaded to 98
      song_sel = 1'b1;
      start    = 1'b1;
      step(1);
      start    = 1'b0;
      chk("s1song_score_clr", score, 7'd0);
      step(1);                                // Q, counter 0
      chk("song1_note", note, 4'd2);
      chk("song1_led", led, 8'h02);
      force dut.score_q = 7'd98;
      step(1);                                // counter 1
      release dut.score_q;
      chk("preload", score, 7'd98);
      for (int m = 0; m < 32; m++) begin
         key = 8'h02;
         step(1);
         key = 8'h00;
         step(3);                             // counter 5
         chk($sformatf("sat_hit_%0d", m), {hit, miss}, 2'b10);
         chk($sformatf("sat_score_%0d", m), score, 7'd99);
         if (m < 31) step(13);
      end
      step(10);                               // slot 31, counter 15
      chk("full_pre_done", done, 1'b0);
      step(1);
      chk("full_done", done, 1'b1);
      chk("full_score", score, 7'd99);

      // abort with simultaneous start in PLAY
      song_sel = 1'b0;
      start    = 1'b1;
      step(1);
      start    = 1'b0;
      step(1);                                // PLAY counter 0
      key = 8'h01;
      step(1);
      key = 8'h00;
      step(3);
      chk("ab_hit", hit, 1'b1);
      abort = 1'b1;
      start = 1'b1;
      step(1);
      abort = 1'b0;
      start = 1'b0;
      chk("ab_busy", busy, 1'b0);
      chk("ab_done", done, 1'b0);
      chk("ab_note", note, 4'h0);
      chk("ab_led", led, 8'h00);
      chk("ab_score", score, 7'd1);
      step(1);
      chk("ab_stay_idle", busy, 1'b0);

      // reset asserted mid-PLAY while hit is high
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
      key = 8'h01;
      step(1);
      key = 8'h00;
      step(3);
      chk("rp_hit", hit, 1'b1);
      RESETN = 1'b1;
      #1;
      chk("rp_pulses", {hit, miss}, 2'b00);
      chk("rp_note_led", {note, led}, 12'h000);
      chk("rp_score", score, 7'd0);
      chk("rp_status", {busy, done}, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
